// File: rtl/sram_wl_sequencer.sv
// sram_wl_sequencer: registered, timed wordline sequencer for an SRAM array.
// Each accepted access one-hot decodes its read and write row addresses.
// The decoded wordlines are held for WL_PULSE cycles. A PRECHARGE gap follows
// before the next access is accepted.
// Optional feature macro: SRAM_WL_RW_CONFLICT_BLOCK_EN. When it is defined, a read
// that targets the row being written is suppressed, and conflict pulses.
module sram_wl_sequencer #(
    parameter int ADDR_W    = 7,
    parameter int ROWS      = 128,
    parameter int NUM_RD    = 2,
    parameter int WL_PULSE  = 2,
    parameter int PRECHARGE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     wr_en,
    output logic [NUM_RD*ROWS-1:0]   read_wl,
    output logic [ROWS-1:0]          write_wl,
    output logic                     busy,
    output logic                     done,
    output logic                     addr_err,
    output logic                     conflict
);

    localparam int MAXC  = (WL_PULSE > PRECHARGE) ? WL_PULSE : PRECHARGE;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(WL_PULSE - 1);
    localparam logic [CNT_W-1:0]  PRECH_LAST = CNT_W'((PRECHARGE > 0) ? PRECHARGE - 1 : 0);
    localparam logic [ADDR_W:0]   ROWS_L     = (ADDR_W + 1)'(ROWS);

    typedef enum logic [1:0] {IDLE, ACTIVE, PRECH} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic                    launch;
    logic                    any_en;
    logic                    err_comb;
    logic                    clash_comb;
    logic [NUM_RD*ROWS-1:0]  rd_dec;
    logic [ROWS-1:0]         wr_dec;

    assign any_en    = (|rd_en) | wr_en;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign launch    = (state == IDLE) && req_valid && any_en;

    // Address decode, range check and read/write clash detection for the incoming request
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic              ok;
        logic              wr_ok;
        rd_dec     = '0;
        wr_dec     = '0;
        err_comb   = 1'b0;
        clash_comb = 1'b0;
        wr_ok      = wr_en && ({1'b0, wr_addr} < ROWS_L);
        if (wr_en && !wr_ok) err_comb = 1'b1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (wr_ok && (wr_addr == ADDR_W'(r))) wr_dec[r] = 1'b1;
        end
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            a  = rd_addr[p*ADDR_W +: ADDR_W];
            ok = rd_en[p] && ({1'b0, a} < ROWS_L);
            if (rd_en[p] && !ok) err_comb = 1'b1;
`ifdef SRAM_WL_RW_CONFLICT_BLOCK_EN
            if (ok && wr_ok && (a == wr_addr)) begin
                ok         = 1'b0;
                clash_comb = 1'b1;
            end
`endif
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (ok && (a == ADDR_W'(r))) rd_dec[p*ROWS + r] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and done generation
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && any_en) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (cnt == PULSE_LAST) begin
                    done       = 1'b1;
                    state_next = (PRECHARGE == 0) ? IDLE : PRECH;
                end
            end
            PRECH: begin
                if (cnt == PRECH_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase counter: restarts on every state change, counts within ACTIVE and PRECH
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (state != IDLE)       cnt <= cnt + 1'b1;
    end

    // Wordline and error-flag registers; wordlines load on launch and clear after the last pulse cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_wl  <= '0;
            write_wl <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= launch && err_comb;
            if (launch) begin
                read_wl  <= rd_dec;
                write_wl <= wr_dec;
            end else if (state == ACTIVE && done) begin
                read_wl  <= '0;
                write_wl <= '0;
            end
        end
    end

`ifdef SRAM_WL_RW_CONFLICT_BLOCK_EN
    // Conflict flag pulses in the cycle after a launch that suppressed a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) conflict <= 1'b0;
        else     conflict <= launch && clash_comb;
    end
`else
    assign conflict = 1'b0;
    logic unused_clash;
    assign unused_clash = clash_comb;
`endif

endmodule
